axis_byte_packer: RTL and testbench
===================================

// Module: axis_byte_packer
// PURPOSE
//  Downstream stage of the read side of the AXIS dual-clock FIFO: consumes the 8-bit AXIS byte stream
//  (tdata/tuser/tlast) in the read clock domain and packs it little-endian into OUT_BYTES-wide words
//  with tkeep for the readout bus. A partial word is flushed on tlast, and optionally on an idle timeout.
// PARAMETERS
//  OUT_BYTES       4    bytes per output word (2..8)
//  TUSER_WIDTH     8    tuser width; the tuser of the first byte of a word is carried with that word
//  TIMEOUT_CYCLES  255  idle cycles before a partial flush (used only with AXIS_PACKER_TIMEOUT_EN)
// PORTS
//  clk            in   1              single clock (FIFO read clock)
//  rst            in   1              synchronous, active-high reset
//  s_axis_tdata   in   8              input byte
//  s_axis_tuser   in   TUSER_WIDTH    input sideband
//  s_axis_tlast   in   1              end of frame
//  s_axis_tvalid  in   1
//  s_axis_tready  out  1
//  m_axis_tdata   out  OUT_BYTES*8    packed word, byte 0 in bits [7:0]
//  m_axis_tkeep   out  OUT_BYTES      contiguous low-order ones only
//  m_axis_tuser   out  TUSER_WIDTH
//  m_axis_tlast   out  1
//  m_axis_tvalid  out  1
//  m_axis_tready  in   1
//  word_count     out  32             emitted words, wraps 2^32-1 -> 0
//  frame_count    out  32             emitted words with tlast=1, wraps
// BEHAVIOUR
//  - Reset: all m_axis_* = 0, s_axis_tready = 0 during rst, counters = 0, partial word discarded.
//    Reset mid-word drops the accumulated bytes; no flush.
//  - s_axis_tready = !rst && (!m_axis_tvalid || m_axis_tready). It is combinational from the output slot.
//  - Accumulator FSM: IDLE (idx=0) and FILL (idx 1..OUT_BYTES-1). Each accepted byte is written to lane idx.
//  - A byte completes the word when idx==OUT_BYTES-1 or tlast=1. Then:
//    - acc+byte load the output register in the same edge;
//    - m_axis_tvalid rises on the next cycle (latency 1 cycle from the completing beat);
//    - idx -> 0, and the FSM returns to IDLE.
//  - Otherwise idx++ and the FSM enters or stays in FILL.
//  - tkeep = (1<<(idx+1))-1 for the completing byte. Unused lanes of tdata are zero.
//  - tlast out = tlast of the completing byte. tuser = tuser captured on the idx==0 byte.
//  - Output register: holds data stable while tvalid && !tready. It clears tvalid on a handshake
//    unless it is reloaded in the same edge, which gives full throughput at m_axis_tready=1.
//  - Counters increment on each m_axis handshake: word_count always; frame_count when tlast=1.
//  - A tlast on idx==0 byte is legal: one word, tkeep=1.
//  - An empty output slot with no input changes nothing.
// CONFIGURATION
//  AXIS_PACKER_TIMEOUT_EN defined:
//    - idle counter runs while FSM==FILL and no input beat is accepted; any accepted byte clears it;
//    - when it reaches TIMEOUT_CYCLES and the output slot is free, the partial word is flushed
//      (tkeep=partial, tlast=0), idx -> 0, and the counter clears;
//    - if the slot is busy, the flush waits and the accumulator stays frozen.
//  Not defined: no counter logic; a partial word is held until more bytes or tlast arrive.
// STRUCTURE
//  - Package axis_packer_pkg:
//    - typedef pack_state_e {IDLE, FILL};
//    - function keep_from_idx();
//    - localparam IDX_W = $clog2(OUT_BYTES).
//  - One sub-module, axis_out_reg: output holding register plus valid/ready and counters, parameterised
//    on data width. The packer FSM stays in the top.
// TESTING
//  1. OUT_BYTES=4, m_ready=1, bytes 11,22,33,44, no tlast -> one cycle after the 4th beat:
//     tdata=0x44332211, tkeep=0xF, tlast=0, word_count=1.
//  2. Bytes 11..66 with tlast on 66 -> 0x44332211/keep 0xF, then 0x00006655/keep 0x3/tlast=1,
//     frame_count=1.
//  3. m_ready=0 for 10 cycles, 8 bytes offered -> 4 accepted, s_tready=0 from the cycle after word 1
//     loads, word 1 stable; release -> word 2 follows back-to-back.
//  4. Single byte 0xA5 with tlast and tuser=0x3C -> tdata=0x000000A5, tkeep=0x1, tlast=1, tuser=0x3C.
//  5. TIMEOUT_CYCLES=8, bytes 01,02 then idle:
//     - macro defined -> flush on idle cycle 8: tdata=0x0201, tkeep=0x3, tlast=0;
//     - macro undefined -> no m_valid within 100 cycles.
//  6. rst pulse after 3 bytes, then bytes 0xAA..0xDD -> first word 0xDDCCBBAA, no residue from before the
//     reset, counters restart from 0.

Source files
------------

// File: rtl/axis_packer_pkg.sv
// Shared types and helpers for the AXIS byte packer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package axis_packer_pkg;

  // Accumulator state: IDLE means lane 0 is next, FILL means a partial word is held.
  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } pack_state_e;

  // Lane index is sized for the widest supported word (8 bytes).
  localparam int MAX_OUT_BYTES = 8;
  localparam int IDX_W         = $clog2(MAX_OUT_BYTES);

  // Contiguous low-order keep mask covering lanes 0..idx.
  function automatic logic [MAX_OUT_BYTES-1:0] keep_from_idx(input logic [IDX_W-1:0] idx);
    logic [MAX_OUT_BYTES-1:0] keep;
    for (int i = 0; i < MAX_OUT_BYTES; i++) begin
      keep[i] = (IDX_W'(i) <= idx);
    end
    return keep;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Output holding register for packed words, with valid/ready and word/frame counters.
// Latency: a load is visible on m_axis_* the cycle after load_i.
// Backpressure: holds data stable while tvalid && !tready; slot_free_o tells the producer when it may load.
module axis_out_reg
  import axis_packer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4,
  parameter int USER_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [KEEP_W-1:0] keep_i,
  input  logic [USER_W-1:0] user_i,
  input  logic              last_i,
  output logic              slot_free_o,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [31:0]       word_count_o,
  output logic [31:0]       frame_count_o
);

  logic [DATA_W-1:0] data_q;
  logic [KEEP_W-1:0] keep_q;
  logic [USER_W-1:0] user_q;
  logic              last_q;
  logic              valid_q;
  logic [31:0]       word_q;
  logic [31:0]       frame_q;
  logic              handshake;

  assign handshake   = valid_q && m_axis_tready;
  // A reload in the same edge as a handshake keeps the slot full: full throughput.
  assign slot_free_o = !valid_q || m_axis_tready;

  // Holding register and counters; a load wins over the handshake clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      keep_q  <= '0;
      user_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      word_q  <= '0;
      frame_q <= '0;
    end else begin
      if (load_i) begin
        data_q  <= data_i;
        keep_q  <= keep_i;
        user_q  <= user_i;
        last_q  <= last_i;
        valid_q <= 1'b1;
      end else if (handshake) begin
        valid_q <= 1'b0;
      end
      if (handshake) begin
        word_q <= word_q + 32'd1;
        if (last_q) begin
          frame_q <= frame_q + 32'd1;
        end
      end
    end
  end

  assign m_axis_tdata  = data_q;
  assign m_axis_tkeep  = keep_q;
  assign m_axis_tuser  = user_q;
  assign m_axis_tlast  = last_q;
  assign m_axis_tvalid = valid_q;
  assign word_count_o  = word_q;
  assign frame_count_o = frame_q;

endmodule

// File: rtl/axis_byte_packer.sv
// Packs an 8-bit AXIS byte stream little-endian into OUT_BYTES words with tkeep; flush on tlast (optional idle timeout via AXIS_PACKER_TIMEOUT_EN).
// Latency: word appears on m_axis one cycle after the completing byte is accepted.
// Backpressure: s_axis_tready = !rst && (!m_axis_tvalid || m_axis_tready); accumulator freezes while the output slot is busy.
module axis_byte_packer
  import axis_packer_pkg::*;
#(
  parameter int OUT_BYTES      = 4,
  parameter int TUSER_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             s_axis_tdata,
  input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [OUT_BYTES*8-1:0] m_axis_tdata,
  output logic [OUT_BYTES-1:0]   m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [31:0]            word_count,
  output logic [31:0]            frame_count
);

  localparam int DATA_W = OUT_BYTES * 8;

  pack_state_e            state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]      acc_q, acc_d;
  logic [TUSER_WIDTH-1:0] user_q, user_d;

  logic                   slot_free;
  logic                   accept;
  logic                   complete;
  logic                   flush;
  logic [DATA_W-1:0]      merged;
  logic                   load;
  logic [DATA_W-1:0]      load_data;
  logic [OUT_BYTES-1:0]   load_keep;
  logic [TUSER_WIDTH-1:0] load_user;
  logic                   load_last;

  assign s_axis_tready = !rst && slot_free;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign complete      = (idx_q == IDX_W'(OUT_BYTES - 1)) || s_axis_tlast;

  // Current accumulator with the incoming byte dropped into lane idx.
  always_comb begin
    merged = acc_q;
    for (int l = 0; l < OUT_BYTES; l++) begin
      if (idx_q == IDX_W'(l)) begin
        merged[l*8 +: 8] = s_axis_tdata;
      end
    end
  end

`ifdef AXIS_PACKER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] idle_q, idle_d;
  logic            timeout_hit;

  // Hit on the TIMEOUT_CYCLES-th consecutive idle cycle while a partial word is held.
  assign timeout_hit = (state_q == FILL) && (idle_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign flush       = timeout_hit && !accept && slot_free && !rst;

  // Idle counter: clears on any accepted byte or flush, saturates while the flush waits for the slot.
  always_comb begin
    idle_d = idle_q;
    if (state_q == IDLE || accept || flush) begin
      idle_d = '0;
    end else if (!timeout_hit) begin
      idle_d = idle_q + TO_W'(1);
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  // Without the timeout a partial word waits indefinitely for more bytes or tlast.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign flush              = 1'b0;
`endif

  // Packer FSM next state and output-register load decision.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    user_d    = user_q;
    load      = 1'b0;
    load_data = merged;
    load_keep = OUT_BYTES'(keep_from_idx(idx_q));
    load_user = (state_q == IDLE) ? s_axis_tuser : user_q;
    load_last = s_axis_tlast;
    if (accept) begin
      if (complete) begin
        load    = 1'b1;
        state_d = IDLE;
        idx_d   = '0;
        acc_d   = '0;
      end else begin
        state_d = FILL;
        idx_d   = idx_q + IDX_W'(1);
        acc_d   = merged;
        if (state_q == IDLE) begin
          user_d = s_axis_tuser;
        end
      end
    end else if (flush) begin
      // Partial flush: idx_q bytes are held, so keep covers lanes 0..idx_q-1.
      load      = 1'b1;
      load_data = acc_q;
      load_keep = OUT_BYTES'(keep_from_idx(idx_q - IDX_W'(1)));
      load_user = user_q;
      load_last = 1'b0;
      state_d   = IDLE;
      idx_d     = '0;
      acc_d     = '0;
    end
  end

  // Packer state register; reset drops any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      user_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      user_q  <= user_d;
    end
  end

  axis_out_reg #(
    .DATA_W (DATA_W),
    .KEEP_W (OUT_BYTES),
    .USER_W (TUSER_WIDTH)
  ) u_out_reg (
    .clk           (clk),
    .rst           (rst),
    .load_i        (load),
    .data_i        (load_data),
    .keep_i        (load_keep),
    .user_i        (load_user),
    .last_i        (load_last),
    .slot_free_o   (slot_free),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .word_count_o  (word_count),
    .frame_count_o (frame_count)
  );

endmodule

// File: tb/tb_axis_byte_packer.sv
// Bench for axis_byte_packer: directed scenarios plus randomized traffic against a frame-level model.
// Latency: expects words one cycle after the completing byte.
// Backpressure: drives random m_axis_tready stalls.
module tb_axis_byte_packer;

  localparam int OB = 4;
  localparam int UW = 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    s_axis_tdata;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tlast;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [OB*8-1:0] m_axis_tdata;
  logic [OB-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [31:0]   word_count;
  logic [31:0]   frame_count;

  always #5 clk = ~clk;

  axis_byte_packer #(
    .OUT_BYTES      (OB),
    .TUSER_WIDTH    (UW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .word_count    (word_count),
    .frame_count   (frame_count)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic [7:0]  user;
    logic        last;
  } word_t;

  word_t       exp_q[$];
  word_t       obs_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          mdl_n = 0;
  logic [31:0] mdl_data = '0;
  logic [7:0]  mdl_user = '0;
  int          hs_cnt = 0;
  int          fr_cnt = 0;

  // Frame-level model: collect accepted bytes, cut a word at OB bytes or tlast; log output handshakes.
  always @(negedge clk) begin
    word_t w;
    if (rst) begin
      mdl_n = 0;
      mdl_data = '0;
      hs_cnt = 0;
      fr_cnt = 0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        w.data = m_axis_tdata; w.keep = m_axis_tkeep; w.user = m_axis_tuser; w.last = m_axis_tlast;
        obs_q.push_back(w);
        hs_cnt++;
        if (m_axis_tlast) fr_cnt++;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        if (mdl_n == 0) mdl_user = s_axis_tuser;
        mdl_data[mdl_n*8 +: 8] = s_axis_tdata;
        mdl_n++;
        if (mdl_n == OB || s_axis_tlast) begin
          w.data = mdl_data; w.keep = 4'((1 << mdl_n) - 1); w.user = mdl_user; w.last = s_axis_tlast;
          exp_q.push_back(w);
          mdl_n = 0;
          mdl_data = '0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] u, input logic l);
    bit done = 1'b0;
    s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (s_axis_tready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL send_accept: byte %h not accepted within 50 cycles", d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} !== 46'd0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%b d=%h k=%h u=%h l=%b want all zero",
                         m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast);
    end
    n_cmp++;
    if ({word_count, frame_count} !== 64'd0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", word_count, frame_count);
    end
    n_cmp++;
    if (s_axis_tready !== 1'b0) begin
      n_fail++; $display("FAIL reset_tready: got %b want 0", s_axis_tready);
    end
    s_axis_tvalid = 1'b0; rst = 1'b0;
    tick();
    n_cmp++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++; $display("FAIL idle_tready: got %b want 1", s_axis_tready);
    end
  endtask

  task automatic test_full_word();
    m_axis_tready = 1'b1;
    send(8'h11, 8'h07, 1'b0); send(8'h22, 8'h00, 1'b0);
    send(8'h33, 8'h00, 1'b0); send(8'h44, 8'h00, 1'b0);
    n_cmp++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== {1'b1, 32'h44332211, 4'hF, 1'b0, 8'h07}) begin
      n_fail++; $display("FAIL full_word: got v=%b d=%h k=%h l=%b u=%h want 1/44332211/f/0/07",
                         m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser);
    end
    tick();
    n_cmp++;
    if ({m_axis_tvalid, word_count} !== {1'b0, 32'd1}) begin
      n_fail++; $display("FAIL full_word_count: got v=%b wc=%0d want 0/1", m_axis_tvalid, word_count);
    end
  endtask

  task automatic test_tlast_flush();
    logic [7:0] b [6];
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int i = 0; i < 4; i++) send(b[i], 8'h10 + 8'(i), 1'b0);
    n_cmp++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== {1'b1, 32'h44332211, 4'hF, 1'b0}) begin
      n_fail++; $display("FAIL tlast_word1: got v=%b d=%h k=%h l=%b want 1/44332211/f/0",
                         m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
    end
    send(b[4], 8'h14, 1'b0); send(b[5], 8'h15, 1'b1);
    n_cmp++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== {1'b1, 32'h00006655, 4'h3, 1'b1, 8'h14}) begin
      n_fail++; $display("FAIL tlast_word2: got v=%b d=%h k=%h l=%b u=%h want 1/00006655/3/1/14",
                         m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser);
    end
    tick();
    n_cmp++;
    if ({frame_count, word_count} !== {32'd1, 32'd3}) begin
      n_fail++; $display("FAIL tlast_counts: got fc=%0d wc=%0d want 1/3", frame_count, word_count);
    end
  endtask

  task automatic test_single();
    send(8'hA5, 8'h3C, 1'b1);
    n_cmp++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== {1'b1, 32'h000000A5, 4'h1, 1'b1, 8'h3C}) begin
      n_fail++; $display("FAIL single_byte: got v=%b d=%h k=%h l=%b u=%h want 1/000000a5/1/1/3c",
                         m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0]  b [8];
    logic [7:0]  u [8];
    logic [31:0] w1, w2;
    int acc = 0;
    int cyc = 0;
    bit a;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 8; i++) begin b[i] = 8'($urandom); u[i] = 8'($urandom); end
    w1 = {b[3], b[2], b[1], b[0]};
    w2 = {b[7], b[6], b[5], b[4]};
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = b[0]; s_axis_tuser = u[0]; s_axis_tlast = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      a = s_axis_tready;
      if (acc == 4) begin
        n_cmp++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tdata} !== {1'b0, 1'b1, w1}) begin
          n_fail++; $display("FAIL bp_stall: got rdy=%b v=%b d=%h want 0/1/%h", s_axis_tready, m_axis_tvalid, m_axis_tdata, w1);
        end
      end
      @(posedge clk); #1;
      if (a) begin acc++; if (acc < 8) begin s_axis_tdata = b[acc]; s_axis_tuser = u[acc]; end end
    end
    n_cmp++;
    if (acc !== 4) begin
      n_fail++; $display("FAIL bp_accepted: got %0d bytes want 4", acc);
    end
    m_axis_tready = 1'b1;
    while (acc < 8 && cyc < 20) begin
      @(negedge clk);
      a = s_axis_tready;
      @(posedge clk); #1;
      cyc++;
      if (a) begin acc++; if (acc < 8) begin s_axis_tdata = b[acc]; s_axis_tuser = u[acc]; end end
    end
    s_axis_tvalid = 1'b0;
    n_cmp++;
    if (cyc !== 4) begin
      n_fail++; $display("FAIL bp_release_cycles: got %0d want 4", cyc);
    end
    n_cmp++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tuser} !== {1'b1, w2, u[4]}) begin
      n_fail++; $display("FAIL bp_word2: got v=%b d=%h u=%h want 1/%h/%h", m_axis_tvalid, m_axis_tdata, m_axis_tuser, w2, u[4]);
    end
    n_cmp++;
    if (obs_q.size() != 1 || obs_q[0].data !== w1 || obs_q[0].user !== u[0]) begin
      n_fail++; $display("FAIL bp_word1_handshake: got %0d words first=%h want 1 word %h", obs_q.size(),
                         (obs_q.size() > 0) ? obs_q[0].data : 32'h0, w1);
    end
    tick();
  endtask

  task automatic test_timeout();
    m_axis_tready = 1'b1;
    send(8'h01, 8'h55, 1'b0); send(8'h02, 8'h66, 1'b0);
`ifdef AXIS_PACKER_TIMEOUT_EN
    begin
      int first = 0;
      logic [44:0] got = '0;
      for (int k = 1; k <= 12; k++) begin
        tick();
        if (m_axis_tvalid && first == 0) begin
          first = k;
          got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        end
      end
      n_cmp++;
      if (first !== 8) begin
        n_fail++; $display("FAIL timeout_cycle: flush seen after %0d idle cycles want 8", first);
      end
      n_cmp++;
      if (got !== {32'h00000201, 4'h3, 1'b0, 8'h55}) begin
        n_fail++; $display("FAIL timeout_word: got %h want %h", got, {32'h00000201, 4'h3, 1'b0, 8'h55});
      end
      mdl_n = 0; mdl_data = '0;
    end
`else
    begin
      bit seen = 1'b0;
      repeat (100) begin tick(); if (m_axis_tvalid) seen = 1'b1; end
      n_cmp++;
      if (seen !== 1'b0) begin
        n_fail++; $display("FAIL no_timeout: got m_valid=1 during 100 idle cycles want none");
      end
      send(8'h03, 8'h77, 1'b1);
      n_cmp++;
      if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== {1'b1, 32'h00030201, 4'h7, 1'b1, 8'h55}) begin
        n_fail++; $display("FAIL held_partial: got v=%b d=%h k=%h l=%b u=%h want 1/00030201/7/1/55",
                           m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser);
      end
      tick();
    end
`endif
  endtask

  task automatic test_reset_mid();
    m_axis_tready = 1'b1;
    send(8'h91, 8'h01, 1'b0); send(8'h92, 8'h01, 1'b0); send(8'h93, 8'h01, 1'b0);
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({s_axis_tready, m_axis_tvalid, word_count, frame_count} !== {1'b0, 1'b0, 64'd0}) begin
      n_fail++; $display("FAIL mid_reset_state: got rdy=%b v=%b wc=%0d fc=%0d want 0/0/0/0",
                         s_axis_tready, m_axis_tvalid, word_count, frame_count);
    end
    rst = 1'b0;
    send(8'hAA, 8'h42, 1'b0); send(8'hBB, 8'h00, 1'b0);
    send(8'hCC, 8'h00, 1'b0); send(8'hDD, 8'h00, 1'b0);
    n_cmp++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser} !== {1'b1, 32'hDDCCBBAA, 4'hF, 8'h42}) begin
      n_fail++; $display("FAIL mid_reset_word: got v=%b d=%h k=%h u=%h want 1/ddccbbaa/f/42",
                         m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser);
    end
    tick();
    n_cmp++;
    if ({word_count, frame_count} !== {32'd1, 32'd0}) begin
      n_fail++; $display("FAIL mid_reset_counts: got wc=%0d fc=%0d want 1/0", word_count, frame_count);
    end
  endtask

  task automatic test_random();
    bit sdone = 1'b0;
    int n;
    exp_q.delete(); obs_q.delete();
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          send(8'($urandom), 8'($urandom), ($urandom_range(0, 5) == 0));
        end
        send(8'($urandom), 8'($urandom), 1'b1);
        sdone = 1'b1;
      end
      begin
        int low = 0;
        while (!sdone) begin
          if (low >= 2 || $urandom_range(0, 3) != 0) begin m_axis_tready = 1'b1; low = 0; end
          else begin m_axis_tready = 1'b0; low++; end
          tick();
        end
      end
    join
    m_axis_tready = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_word_total: got %0d words want %0d", obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if ({obs_q[i].data, obs_q[i].keep, obs_q[i].user, obs_q[i].last} !==
          {exp_q[i].data, exp_q[i].keep, exp_q[i].user, exp_q[i].last}) begin
        n_fail++; $display("FAIL rand_word[%0d]: got d=%h k=%h u=%h l=%b want d=%h k=%h u=%h l=%b", i,
                           obs_q[i].data, obs_q[i].keep, obs_q[i].user, obs_q[i].last,
                           exp_q[i].data, exp_q[i].keep, exp_q[i].user, exp_q[i].last);
      end
    end
    n_cmp++;
    if ({word_count, frame_count} !== {32'(hs_cnt), 32'(fr_cnt)}) begin
      n_fail++; $display("FAIL rand_counters: got wc=%0d fc=%0d want %0d/%0d", word_count, frame_count, hs_cnt, fr_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    s_axis_tdata = '0; s_axis_tuser = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    test_reset();
    test_full_word();
    test_tlast_flush();
    test_single();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
